// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg: shared fetch widths, opcode classes and fetch state encoding
package inst_fetch_pkg;
  localparam int instWidth = 32;
  localparam int addrWidth = 32;
  localparam logic [6:0] classBranch = 7'b1100011;
  localparam logic [6:0] classJAL = 7'b1101111;
  localparam logic [6:0] classJALR = 7'b1100111;
  typedef enum logic [1:0] {FETCH, ISSUE, WAIT_JUMP} fetch_state_t;
  function automatic logic is_ctrl(input logic [6:0] op);
    return op == classBranch || op == classJAL || op == classJALR;
  endfunction
endpackage

// File: rtl/fetch_byte_assembler.sv
// fetch_byte_assembler: collects four returned bytes into a little-endian word
module fetch_byte_assembler
  import inst_fetch_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 accept,
  input  logic [7:0]           rdata,
  output logic [instWidth-1:0] word,
  output logic                 done
);
  logic [1:0] rcv_cnt;
  logic pend, drop, capture;
  assign capture = pend && !drop && !clear;
  assign done = capture && rcv_cnt == 2'd3;
  // track the byte due next cycle, discard anything that was in flight across a clear
  always_ff @(posedge clk) begin
    if (rst) begin
      word <= '0;
      rcv_cnt <= '0;
      pend <= 1'b0;
      drop <= 1'b0;
    end else begin
      pend <= accept;
      drop <= clear;
      if (clear) rcv_cnt <= '0;
      else if (capture) begin
        word[{rcv_cnt, 3'b000} +: 8] <= rdata;
        rcv_cnt <= rcv_cnt + 2'd1;
      end
    end
  end
endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: byte-serial instruction fetch with decode handshake and jump stall
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = addrWidth,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ready,
  input  logic [7:0]            mem_rdata,
  output logic                  decoderEnable,
  output logic [instWidth-1:0]  instToDecode,
  output logic [ADDR_WIDTH-1:0] inst_PC,
  input  logic                  dec_stall,
  input  logic                  jump_valid,
  input  logic [ADDR_WIDTH-1:0] jump_target
);
  fetch_state_t state, state_nx;
  logic [ADDR_WIDTH-1:0] pc, pc_nx;
  logic [2:0] req_cnt, req_cnt_nx;
  logic accept, clear, done, issue;
  logic [instWidth-1:0] buffer;
  fetch_byte_assembler u_asm (
    .clk    (clk),
    .rst    (rst),
    .clear  (clear),
    .accept (accept),
    .rdata  (mem_rdata),
    .word   (buffer),
    .done   (done)
  );
  // outputs and next state; a redirect overrides everything else
  always_comb begin
    issue = state == ISSUE && !rst;
    mem_rd_en = state == FETCH && req_cnt < 3'd4 && !jump_valid && !rst;
    mem_addr = rst ? '0 : pc + ADDR_WIDTH'(req_cnt);
    decoderEnable = issue && !jump_valid;
    instToDecode = issue ? buffer : '0;
    inst_PC = issue ? pc : '0;
    accept = mem_rd_en && mem_ready;
    state_nx = state;
    pc_nx = pc;
    req_cnt_nx = accept ? req_cnt + 3'd1 : req_cnt;
    clear = 1'b0;
    if (state == FETCH && done) state_nx = ISSUE;
    if (decoderEnable && !dec_stall) begin
      state_nx = is_ctrl(buffer[6:0]) ? WAIT_JUMP : FETCH;
      pc_nx = is_ctrl(buffer[6:0]) ? pc : pc + ADDR_WIDTH'(4);
      req_cnt_nx = '0;
      clear = 1'b1;
    end
    if (jump_valid) begin
      state_nx = FETCH;
      pc_nx = jump_target & ~ADDR_WIDTH'(3);
      req_cnt_nx = '0;
      clear = 1'b1;
    end
  end
  // state, PC and request counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      pc <= RESET_PC;
      req_cnt <= '0;
    end else begin
      state <= state_nx;
      pc <= pc_nx;
      req_cnt <= req_cnt_nx;
    end
  end
endmodule
